myproject_mac_pipe: RTL and testbench
=====================================

MYPROJECT_MAC_PIPE -- requirements
Module: myproject_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 24: operand A width.
REQ-002 SHALL have parameter DIN1_WIDTH, default 18: operand B width.
REQ-003 SHALL have parameter DIN0_SIGNED, default 0: 1 means A is two's complement, 0 means A is zero-extended.
REQ-004 SHALL have parameter DIN1_SIGNED, default 1: the same rule for B.
REQ-005 SHALL have parameter NUM_STAGE, default 4, legal range 3..8: total pipeline depth.
REQ-006 SHALL have parameter ACC_WIDTH, default 48: accumulator width, at least DIN0_WIDTH+DIN1_WIDTH+1.
REQ-007 SHALL have parameter DOUT_WIDTH, default 37: output width.
REQ-008 SHALL have parameter SHIFT, default 0: right-shift applied at output, range 0..ACC_WIDTH-1.
REQ-009 SHALL have parameter SATURATE, default 1: 1 means saturate, 0 means truncate.
REQ-010 clk  in  1  the single clock; all state updates on its rising edge.
REQ-011 reset  in  1  asynchronous, active-low reset.
REQ-012 ce  in  1  clock enable; all state holds when low.
REQ-013 din_valid  in  1  qualifies din0/din1/acc_en/acc_last.
REQ-014 din0  in  DIN0_WIDTH  operand A.
REQ-015 din1  in  DIN1_WIDTH  operand B.
REQ-016 acc_en  in  1  the product joins the running sum.
REQ-017 acc_last  in  1  closes the sum, emits it, then clears it.
REQ-018 dout_valid  out  1  dout/ovf valid for this cycle.
REQ-019 dout  out  DOUT_WIDTH  signed result.
REQ-020 ovf  out  1  the result was saturated; pulse, qualified by dout_valid.

Function
REQ-021 Stage 1 SHALL register din0, din1 and all control signals; stage 2 SHALL register the full-precision product of width DIN0_WIDTH+DIN1_WIDTH+1, signed.
REQ-022 Each operand SHALL be extended per its *_SIGNED parameter before multiplying; for unsigned A this is an explicit leading 0.
REQ-023 Stages 3..NUM_STAGE-1 SHALL be pure delay registers carrying the product and its control signals.
REQ-024 Stage NUM_STAGE SHALL perform accumulation, output conversion and register dout, dout_valid and ovf.
REQ-025 Latency SHALL be exactly NUM_STAGE ce-high cycles from sampling an input to the corresponding dout_valid.
REQ-026 When ce is low, every register SHALL hold, including the valid pipeline; dout_valid SHALL hold its value.
REQ-027 Final stage, valid with acc_en=0: the output SHALL be the sign-extended product; the accumulator SHALL be untouched; acc_last SHALL be ignored.
REQ-028 Final stage, valid with acc_en=1 and acc_last=0: acc SHALL become acc+product; dout_valid SHALL be 0.
REQ-029 Final stage, valid with acc_en=1 and acc_last=1: the output SHALL be acc+product, and acc SHALL be cleared to 0 in the same cycle.
REQ-030 Accumulator overflow SHALL wrap modulo 2^ACC_WIDTH; the accumulator itself is never saturated.
REQ-031 Output conversion SHALL apply an arithmetic right shift by SHIFT with round-half-up (add 2^(SHIFT-1) first when SHIFT>0).
REQ-032 If SATURATE=1, values outside the DOUT_WIDTH signed range SHALL clamp to max/min and assert ovf; otherwise the low bits SHALL be kept and ovf SHALL be 0.
REQ-033 A stage with valid=0 SHALL NOT modify acc and SHALL produce dout_valid=0; dout SHALL then hold its last value.
REQ-034 Back-to-back valid inputs SHALL be accepted every ce cycle; throughput is 1 per cycle with no backpressure.

Reset
REQ-035 Reset assertion SHALL immediately clear all valid bits, the accumulator, dout, dout_valid and ovf to 0, even mid-operation; in-flight data is discarded.
REQ-036 Data-path registers other than those listed in REQ-035 need no reset.
REQ-037 After reset deasserts, the first input SHALL start a fresh sum from 0.

Structure
REQ-038 A shared package SHALL hold the product-width and signed-range min/max constant functions and the round/saturate function.
REQ-039 The delay stages SHALL use one sub-module, myproject_pipe_delay, parametrised by width and depth with ce and reset.

Verification
REQ-040 Defaults, din0=0xFFFFFF, din1=-1, acc_en=0 -> dout=-16777215 exactly 4 cycles later, ovf=0.
REQ-041 Inputs (2,3) acc, (4,5) acc, (1,-7) acc+last on consecutive cycles -> one dout_valid with value 19; a following (1,1) acc+last -> 1.
REQ-042 Inputs din0=0xFFFFFF, din1=0x1FFFF -> dout=2^36-1 with ovf=1; the same case with SATURATE=0 -> low 37 bits, ovf=0.
REQ-043 SHIFT=4, inputs 24*1 -> 2; 23*1 -> 1; 24*-1 -> -1.
REQ-044 Stream 6 inputs with ce low for 3 random cycles -> outputs in order, each delayed by exactly the stall count, none lost or duplicated.
REQ-045 Assert reset mid-accumulation after 2 acc beats -> no dout_valid; a next single acc+last (3,3) -> 9.

Source files
------------

// File: rtl/myproject_mac_pipe_pkg.sv
// Shared constants and helpers for the MAC pipeline: product width, signed range limits,
// and the output round/saturate conversion.
package myproject_mac_pipe_pkg;

  localparam int unsigned WideW = 128;

  typedef logic signed [WideW-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t value;
  } conv_t;

  function automatic int unsigned prod_width(int unsigned w0, int unsigned w1);
    return w0 + w1 + 1;
  endfunction

  function automatic wide_t smax(int unsigned w);
    return (wide_t'(1) << (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t smin(int unsigned w);
    return -(wide_t'(1) << (w - 1));
  endfunction

  // Arithmetic shift with round-half-up, then optional clamp to a dout_w-bit signed range.
  function automatic conv_t round_sat(wide_t val, int unsigned shift, int unsigned dout_w,
                                      bit saturate);
    conv_t r;
    wide_t x;
    x = val;
    if (shift > 0) begin
      x = x + (wide_t'(1) << (shift - 1));
    end
    x = x >>> shift;
    r.ovf   = 1'b0;
    r.value = x;
    if (saturate) begin
      if (x > smax(dout_w)) begin
        r.value = smax(dout_w);
        r.ovf   = 1'b1;
      end else if (x < smin(dout_w)) begin
        r.value = smin(dout_w);
        r.ovf   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_pipe_delay.sv
// Clock-enabled delay line of configurable width and depth; depth 0 is a wire.
module myproject_pipe_delay #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= '0;
        end
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate: register inputs, multiply, optional delay stages, then
// accumulate and convert (round/saturate) in the final stage.
module myproject_mac_pipe
  import myproject_mac_pipe_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 24,
  parameter int unsigned DIN1_WIDTH  = 18,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 1,
  parameter int unsigned NUM_STAGE   = 4,
  parameter int unsigned ACC_WIDTH   = 48,
  parameter int unsigned DOUT_WIDTH  = 37,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ce_i,
  input  logic                  din_valid_i,
  input  logic [DIN0_WIDTH-1:0] din0_i,
  input  logic [DIN1_WIDTH-1:0] din1_i,
  input  logic                  acc_en_i,
  input  logic                  acc_last_i,
  output logic                  dout_valid_o,
  output logic [DOUT_WIDTH-1:0] dout_o,
  output logic                  ovf_o
);

  localparam int unsigned ProdW    = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int unsigned DlyDepth = NUM_STAGE - 3;
  localparam int unsigned DlyW     = ProdW + 3;

  // Stage 1: input registers
  logic                  s1_valid_q, s1_en_q, s1_last_q;
  logic [DIN0_WIDTH-1:0] din0_q;
  logic [DIN1_WIDTH-1:0] din1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
    end else if (ce_i) begin
      s1_valid_q <= din_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      din0_q    <= din0_i;
      din1_q    <= din1_i;
      s1_en_q   <= acc_en_i;
      s1_last_q <= acc_last_i;
    end
  end

  // Stage 2: product; ProdW bits always hold the exact result for these operand kinds
  logic                    a_sign, b_sign;
  logic signed [ProdW-1:0] a_ext, b_ext, prod_d, prod_q;
  logic                    s2_valid_q, s2_en_q, s2_last_q;

  always_comb begin
    a_sign = (DIN0_SIGNED != 0) && din0_q[DIN0_WIDTH-1];
    b_sign = (DIN1_SIGNED != 0) && din1_q[DIN1_WIDTH-1];
    a_ext  = {{(ProdW - DIN0_WIDTH){a_sign}}, din0_q};
    b_ext  = {{(ProdW - DIN1_WIDTH){b_sign}}, din1_q};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
    end else if (ce_i) begin
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      prod_q    <= prod_d;
      s2_en_q   <= s1_en_q;
      s2_last_q <= s1_last_q;
    end
  end

  // Stages 3..NUM_STAGE-1: pure delay
  logic [DlyW-1:0] dly_q;

  myproject_pipe_delay #(
    .Width (DlyW),
    .Depth (DlyDepth)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ce_i   (ce_i),
    .d_i    ({s2_valid_q, s2_en_q, s2_last_q, prod_q}),
    .q_o    (dly_q)
  );

  // Final stage: accumulate, convert, register outputs
  logic                        f_valid, f_en, f_last;
  logic signed [ProdW-1:0]     f_prod;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_ext, sum, conv_in;
  logic [DOUT_WIDTH-1:0]       dout_q, dout_d;
  logic                        dv_q, dv_d, ovf_q, ovf_d;
  conv_t                       conv;
  logic                        unused_conv;

  assign {f_valid, f_en, f_last, f_prod} = dly_q;
  assign prod_ext    = ACC_WIDTH'(f_prod);
  assign sum         = acc_q + prod_ext;
  assign conv_in     = f_en ? sum : prod_ext;
  assign conv        = round_sat(wide_t'(conv_in), SHIFT, DOUT_WIDTH, SATURATE != 0);
  assign unused_conv = ^conv.value[WideW-1:DOUT_WIDTH];

  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    ovf_d  = 1'b0;
    if (f_valid && f_en) begin
      acc_d = f_last ? '0 : sum;
    end
    if (f_valid && (!f_en || f_last)) begin
      dv_d   = 1'b1;
      dout_d = conv.value[DOUT_WIDTH-1:0];
      ovf_d  = conv.ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ce_i) begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout_valid_o = dv_q;
  assign dout_o       = dout_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: four instances (default, no-saturate, SHIFT=4,
// NUM_STAGE=3) share one stimulus stream.
module tb_myproject_mac_pipe;

  localparam int unsigned W0 = 24;
  localparam int unsigned W1 = 18;
  localparam int unsigned DW = 37;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ce_i = 1'b0;
  logic          din_valid_i = 1'b0;
  logic          acc_en_i = 1'b0;
  logic          acc_last_i = 1'b0;
  logic [W0-1:0] din0_i = '0;
  logic [W1-1:0] din1_i = '0;

  logic          dv_a, ovf_a, dv_n, ovf_n, dv_s, ovf_s, dv_3, ovf_3;
  logic [DW-1:0] dout_a, dout_n, dout_s, dout_3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  myproject_mac_pipe u_dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .ce_i (ce_i), .din_valid_i (din_valid_i),
    .din0_i (din0_i), .din1_i (din1_i), .acc_en_i (acc_en_i), .acc_last_i (acc_last_i),
    .dout_valid_o (dv_a), .dout_o (dout_a), .ovf_o (ovf_a)
  );

  myproject_mac_pipe #(.SATURATE (0)) u_nosat (
    .clk_i (clk_i), .rst_ni (rst_ni), .ce_i (ce_i), .din_valid_i (din_valid_i),
    .din0_i (din0_i), .din1_i (din1_i), .acc_en_i (acc_en_i), .acc_last_i (acc_last_i),
    .dout_valid_o (dv_n), .dout_o (dout_n), .ovf_o (ovf_n)
  );

  myproject_mac_pipe #(.SHIFT (4)) u_shift (
    .clk_i (clk_i), .rst_ni (rst_ni), .ce_i (ce_i), .din_valid_i (din_valid_i),
    .din0_i (din0_i), .din1_i (din1_i), .acc_en_i (acc_en_i), .acc_last_i (acc_last_i),
    .dout_valid_o (dv_s), .dout_o (dout_s), .ovf_o (ovf_s)
  );

  myproject_mac_pipe #(.NUM_STAGE (3)) u_ns3 (
    .clk_i (clk_i), .rst_ni (rst_ni), .ce_i (ce_i), .din_valid_i (din_valid_i),
    .din0_i (din0_i), .din1_i (din1_i), .acc_en_i (acc_en_i), .acc_last_i (acc_last_i),
    .dout_valid_o (dv_3), .dout_o (dout_3), .ovf_o (ovf_3)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] d37(input longint v);
    logic [DW-1:0] t;
    t = DW'(v);
    return 64'(t);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b, input logic en,
                      input logic last);
    din_valid_i = 1'b1;
    din0_i      = a;
    din1_i      = b;
    acc_en_i    = en;
    acc_last_i  = last;
    tick();
    din_valid_i = 1'b0;
    acc_en_i    = 1'b0;
    acc_last_i  = 1'b0;
  endtask

  initial begin
    int            edge_n;
    int            sent;
    int            got;
    logic          prev_dv;
    logic [DW-1:0] prev_dout;
    bit            exp_v [64];
    logic [DW-1:0] exp_d [64];

    ce_i = 1'b1;
    #12;
    check_eq("rst_dv", 64'(dv_a), 64'(0));
    check_eq("rst_dout", 64'(dout_a), 64'(0));
    check_eq("rst_ovf", 64'(ovf_a), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Unsigned A times signed B, latency 4 (and 3 on the short pipe)
    send(24'hFFFFFF, W1'(-1), 1'b0, 1'b0);
    idle(2);
    check_eq("lat_early_dv", 64'(dv_a), 64'(0));
    check_eq("ns3_dv", 64'(dv_3), 64'(1));
    check_eq("ns3_dout", 64'(dout_3), d37(-16777215));
    idle(1);
    check_eq("mul_dv", 64'(dv_a), 64'(1));
    check_eq("mul_dout", 64'(dout_a), d37(-16777215));
    check_eq("mul_ovf", 64'(ovf_a), 64'(0));
    idle(1);
    check_eq("idle_dv", 64'(dv_a), 64'(0));
    check_eq("idle_hold", 64'(dout_a), d37(-16777215));

    // Accumulation: 6 + 20 - 7 = 19, then a fresh single-beat sum of 1
    send(24'd2, W1'(3), 1'b1, 1'b0);
    send(24'd4, W1'(5), 1'b1, 1'b0);
    send(24'd1, W1'(-7), 1'b1, 1'b1);
    idle(1);
    check_eq("acc_mid1_dv", 64'(dv_a), 64'(0));
    idle(1);
    check_eq("acc_mid2_dv", 64'(dv_a), 64'(0));
    idle(1);
    check_eq("acc_sum_dv", 64'(dv_a), 64'(1));
    check_eq("acc_sum", 64'(dout_a), d37(19));
    send(24'd1, W1'(1), 1'b1, 1'b1);
    idle(3);
    check_eq("acc_fresh_dv", 64'(dv_a), 64'(1));
    check_eq("acc_fresh", 64'(dout_a), d37(1));

    // Saturation at max and min; truncation when SATURATE=0
    send(24'hFFFFFF, 18'h1FFFF, 1'b0, 1'b0);
    idle(3);
    check_eq("satmax_dv", 64'(dv_a), 64'(1));
    check_eq("satmax_dout", 64'(dout_a), 64'h0F_FFFF_FFFF);
    check_eq("satmax_ovf", 64'(ovf_a), 64'(1));
    check_eq("trunc_dout", 64'(dout_n), 64'd137422045185);
    check_eq("trunc_ovf", 64'(ovf_n), 64'(0));
    send(24'hFFFFFF, 18'h20000, 1'b0, 1'b0);
    idle(3);
    check_eq("satmin_dout", 64'(dout_a), 64'h10_0000_0000);
    check_eq("satmin_ovf", 64'(ovf_a), 64'(1));

    // Rounding shift, back-to-back inputs
    send(24'd24, W1'(1), 1'b0, 1'b0);
    send(24'd23, W1'(1), 1'b0, 1'b0);
    send(24'd24, W1'(-1), 1'b0, 1'b0);
    idle(1);
    check_eq("shift_24", 64'(dout_s), d37(2));
    check_eq("b2b_24", 64'(dout_a), d37(24));
    idle(1);
    check_eq("shift_23", 64'(dout_s), d37(1));
    check_eq("b2b_23", 64'(dout_a), d37(23));
    idle(1);
    check_eq("shift_m24", 64'(dout_s), d37(-1));
    check_eq("shift_ovf", 64'(ovf_s), 64'(0));
    check_eq("b2b_m24_dv", 64'(dv_a), 64'(1));

    // Stream 6 products with 3 stalled cycles; junk offered while stalled must be ignored
    edge_n = 0;
    sent   = 0;
    got    = 0;
    for (int i = 0; i < 64; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      prev_dv   = dv_a;
      prev_dout = dout_a;
      ce_i      = !(cyc == 1 || cyc == 4 || cyc == 5);
      if (!ce_i) begin
        din_valid_i = 1'b1;
        din0_i      = 24'd99;
        din1_i      = W1'(99);
      end else if (sent < 6) begin
        din_valid_i         = 1'b1;
        din0_i              = W0'(sent + 1);
        din1_i              = W1'(10);
        exp_v[edge_n + 4]   = 1'b1;
        exp_d[edge_n + 4]   = DW'((sent + 1) * 10);
        sent++;
      end else begin
        din_valid_i = 1'b0;
      end
      tick();
      if (ce_i) begin
        edge_n++;
        check_eq("stream_dv", 64'(dv_a), 64'(exp_v[edge_n]));
        if (exp_v[edge_n]) begin
          check_eq("stream_dout", 64'(dout_a), 64'(exp_d[edge_n]));
          got++;
        end
      end else begin
        check_eq("stall_dv_hold", 64'(dv_a), 64'(prev_dv));
        check_eq("stall_dout_hold", 64'(dout_a), 64'(prev_dout));
      end
    end
    din_valid_i = 1'b0;
    ce_i        = 1'b1;
    check_eq("stream_count", 64'(got), 64'(6));

    // Reset mid-accumulation discards the running sum and the in-flight closing beat
    send(24'd5, W1'(5), 1'b1, 1'b0);
    send(24'd7, W1'(7), 1'b1, 1'b0);
    send(24'd6, W1'(6), 1'b1, 1'b1);
    idle(2);
    check_eq("pre_rst_dv", 64'(dv_a), 64'(0));
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_dout", 64'(dout_a), 64'(0));
    check_eq("async_rst_dv", 64'(dv_a), 64'(0));
    idle(2);
    check_eq("in_rst_dv", 64'(dv_a), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    send(24'd3, W1'(3), 1'b1, 1'b1);
    idle(2);
    check_eq("post_rst_early_dv", 64'(dv_a), 64'(0));
    idle(1);
    check_eq("post_rst_dv", 64'(dv_a), 64'(1));
    check_eq("post_rst_sum", 64'(dout_a), d37(9));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
